// File: rtl/fwrisc_ifetch_prefetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fwrisc_ifetch_prefetch_if
// Purpose : Hold-until-ready fetch handshake (address, valid, ready, data),
//           used for both the core-facing and the memory-facing port.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
interface fwrisc_ifetch_prefetch_if;
  logic [31:0] addr;
  logic        valid;
  logic        ready;
  logic [31:0] rdata;

  // Requester: drives address/valid and receives ready/data.
  modport master (output addr, output valid, input ready, input rdata);
  // Responder: receives address/valid and drives ready/data.
  modport slave  (input addr, input valid, output ready, output rdata);
endinterface
`default_nettype wire

// File: rtl/fwrisc_ifetch_prefetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fwrisc_ifetch_prefetch
// Purpose : Sequential instruction prefetch FIFO between the fwrisc core
//           fetch port and instruction memory. Straight-line code hits in
//           the same cycle; any non-sequential request flushes and restarts.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module fwrisc_ifetch_prefetch #(
  parameter int DEPTH = 4
) (
  input  wire logic                 clock,
  input  wire logic                 reset,
  fwrisc_ifetch_prefetch_if.slave   core,
  fwrisc_ifetch_prefetch_if.master  mem
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

  // Stream state
  logic               r_active;
  logic               r_busy;
  logic               r_discard;
  logic [31:2]        r_fa;
  logic [31:2]        r_npc;
  logic [31:2]        r_head;
  logic [c_PTR_W:0]   r_count;
  logic [c_PTR_W-1:0] r_rd;
  logic [c_PTR_W-1:0] r_wr;
  logic [31:0]        r_fifo [DEPTH];

  logic               w_active;
  logic               w_busy;
  logic               w_discard;
  logic [31:2]        w_fa;
  logic [31:2]        w_npc;
  logic [31:2]        w_head;
  logic [c_PTR_W:0]   w_count;
  logic [c_PTR_W-1:0] w_rd;
  logic [c_PTR_W-1:0] w_wr;
  logic               w_push;

  logic               w_match;
  logic               w_hit;
  logic               w_miss;
  logic               w_mdone;
  logic               w_unused_addr_lsb;

  assign w_match = (core.addr[31:2] == r_head);
  assign w_hit   = core.valid && r_active && (r_count != '0) && w_match;
  assign w_miss  = core.valid && (!r_active || !w_match);
  assign w_mdone = r_busy && mem.ready;
  assign w_unused_addr_lsb = &{1'b0, core.addr[1:0]};

  assign core.ready = w_hit;
  assign core.rdata = w_hit ? r_fifo[r_rd] : 32'h0;
  assign mem.valid  = r_busy;
  assign mem.addr   = {r_fa, 2'b00};

  // Next-state for the stream: flush on miss, otherwise pop on hit and
  // advance the fetch address on every memory completion.
  always_comb begin
    w_active  = r_active;
    w_busy    = r_busy;
    w_discard = r_discard;
    w_fa      = r_fa;
    w_npc     = r_npc;
    w_head    = r_head;
    w_count   = r_count;
    w_rd      = r_rd;
    w_wr      = r_wr;
    w_push    = 1'b0;

    if (w_miss) begin
      w_active = 1'b1;
      w_count  = '0;
      w_rd     = '0;
      w_wr     = '0;
      w_head   = core.addr[31:2];
      w_npc    = core.addr[31:2] + 30'd1;
      if (!r_busy || mem.ready) begin
        // Memory is free (or finishing now, its data is stale): restart
        // directly at the requested word.
        w_fa      = core.addr[31:2];
        w_busy    = 1'b1;
        w_discard = 1'b0;
      end else begin
        // A request is in flight and cannot be withdrawn; mark its data
        // stale and park the restart target so completion jumps to it.
        w_discard = 1'b1;
        w_npc     = core.addr[31:2];
      end
    end else begin
      if (w_hit) begin
        w_head = r_head + 30'd1;
        w_rd   = r_rd + 1'b1;
      end
      if (w_mdone) begin
        w_fa  = r_npc;
        w_npc = r_npc + 30'd1;
        if (r_discard) begin
          w_discard = 1'b0;
        end else begin
          w_push = 1'b1;
          w_wr   = r_wr + 1'b1;
        end
        w_count = r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_hit};
        w_busy  = (w_count < c_FULL);
      end else begin
        w_count = r_count - {{c_PTR_W{1'b0}}, w_hit};
        if (!r_busy && r_active && (r_count < c_FULL)) begin
          w_busy = 1'b1;
        end
      end
    end
  end

  // Stream state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_busy    <= 1'b0;
      r_discard <= 1'b0;
      r_fa      <= '0;
      r_npc     <= '0;
      r_head    <= '0;
      r_count   <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
    end else begin
      r_active  <= w_active;
      r_busy    <= w_busy;
      r_discard <= w_discard;
      r_fa      <= w_fa;
      r_npc     <= w_npc;
      r_head    <= w_head;
      r_count   <= w_count;
      r_rd      <= w_rd;
      r_wr      <= w_wr;
    end
  end

  // FIFO storage; contents are only meaningful below r_count so no reset.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_fifo[r_wr] <= mem.rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_ifetch_prefetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_fwrisc_ifetch_prefetch
// Purpose : Self-checking bench for the instruction prefetch buffer.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_fwrisc_ifetch_prefetch;

  logic clock;
  logic reset;
  logic mrdy;

  fwrisc_ifetch_prefetch_if cif();
  fwrisc_ifetch_prefetch_if mif();

  fwrisc_ifetch_prefetch #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .core  (cif),
    .mem   (mif)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic [31:0] mlog[$];

  // Contents of instruction memory as a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ((w ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h0000_1234;
  endfunction

  assign mif.ready = mrdy;
  assign mif.rdata = mem_word(mif.addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mlog_at(input int i);
    if (i < mlog.size()) return mlog[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Scoreboard: every delivered word must match the oldest outstanding request.
  always @(negedge clock) begin
    if (!reset) begin
      if (cif.ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_iready", 32'h1, 32'h0);
        end else begin
          chk("idata", cif.rdata, sb_q.pop_front());
        end
      end else begin
        chk("idata_zero_when_idle", cif.rdata, 32'h0);
      end
    end
  end

  // Memory-side log of completed addresses plus hold-until-ready check.
  logic        prev_v, prev_r, prev_rst;
  logic [31:0] prev_a;
  initial begin prev_v = 0; prev_r = 0; prev_rst = 1; prev_a = 0; end
  always @(negedge clock) begin
    if (prev_v && !prev_r && !prev_rst) begin
      chk("mvalid_held", {31'b0, mif.valid}, 32'h1);
      chk("maddr_held", mif.addr, prev_a);
    end
    if (!reset && mif.valid && mif.ready) mlog.push_back(mif.addr);
    prev_v   = mif.valid;
    prev_r   = mif.ready;
    prev_a   = mif.addr;
    prev_rst = reset;
  end

  // Issue one core fetch, wait for it, and check the stall count.
  task automatic do_fetch(input logic [31:0] a, input int exp_lat);
    int lat;
    lat = 0;
    cif.addr  = a;
    cif.valid = 1'b1;
    sb_q.push_back(mem_word(a));
    forever begin
      @(negedge clock);
      if (cif.ready) break;
      lat++;
      if (lat > 40) break;
    end
    chk("fetch_latency", 32'(lat), 32'(exp_lat));
    if (lat > 40) sb_q.delete();
    @(posedge clock); #1;
    cif.valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cif.valid = 1'b0;
    cif.addr  = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    sb_q.delete();
    mlog.delete();
  endtask

  typedef struct {
    logic [31:0] addr;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit found;
    mrdy      = 1'b1;
    cif.valid = 1'b0;
    cif.addr  = 32'h0;

    vecs[0] = '{32'h0000_0100, 2};
    for (int i = 1; i < 8; i++) vecs[i] = '{32'h0000_0100 + 32'(4*i), 0};
    vecs[8] = '{32'h0000_0200, 2};
    vecs[9] = '{32'h0000_0204, 0};

    // Reset state.
    do_reset();
    @(negedge clock);
    chk("reset_mvalid", {31'b0, mif.valid}, 32'h0);
    chk("reset_iready", {31'b0, cif.ready}, 32'h0);
    chk("reset_idata",  cif.rdata,          32'h0);
    @(posedge clock); #1;

    // Cold start, sequential hits and a branch, table driven.
    for (int i = 0; i < 10; i++) do_fetch(vecs[i].addr, vecs[i].lat);
    chk("cold_maddr0", mlog_at(0), 32'h0000_0100);
    chk("cold_maddr1", mlog_at(1), 32'h0000_0104);
    chk("cold_maddr2", mlog_at(2), 32'h0000_0108);
    chk("cold_maddr3", mlog_at(3), 32'h0000_010C);

    // Full backpressure: exactly four words beyond the demand word.
    do_reset();
    do_fetch(32'h0000_0100, 2);
    repeat (10) @(posedge clock);
    #1;
    chk("bp_push_count", 32'(mlog.size()), 32'd5);
    chk("bp_last_push", mlog_at(4), 32'h0000_0110);
    @(negedge clock);
    chk("bp_mvalid_low", {31'b0, mif.valid}, 32'h0);
    @(posedge clock); #1;
    do_fetch(32'h0000_0104, 0);
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clock);
      if (mif.valid) found = 1'b1;
    end
    chk("bp_restart_seen", {31'b0, found}, 32'h1);
    chk("bp_restart_maddr", mif.addr, 32'h0000_0114);

    // Branch flush from a full buffer.
    repeat (8) @(posedge clock);
    #1;
    mlog.delete();
    do_fetch(32'h0000_0200, 2);
    chk("flush_maddr", mlog_at(0), 32'h0000_0200);
    do_fetch(32'h0000_0204, 0);

    // Redirect while memory is stalled on 0x108.
    mrdy = 1'b0;
    do_reset();
    cif.addr  = 32'h0000_0108;
    cif.valid = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_mvalid", {31'b0, mif.valid}, 32'h1);
      chk("stall_maddr", mif.addr, 32'h0000_0108);
    end
    @(posedge clock); #1;
    cif.addr = 32'h0000_0400;
    sb_q.push_back(mem_word(32'h0000_0400));
    repeat (2) begin
      @(negedge clock);
      chk("redirect_maddr_held", mif.addr, 32'h0000_0108);
      chk("redirect_no_iready", {31'b0, cif.ready}, 32'h0);
    end
    @(posedge clock); #1;
    mrdy  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (cif.ready) found = 1'b1;
    end
    chk("redirect_delivered", {31'b0, found}, 32'h1);
    @(posedge clock); #1;
    cif.valid = 1'b0;
    chk("redirect_mlog0", mlog_at(0), 32'h0000_0108);
    chk("redirect_mlog1", mlog_at(1), 32'h0000_0400);

    // Reset in the middle of a memory request.
    mrdy = 1'b0;
    cif.addr  = 32'h0000_0300;
    cif.valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("midreset_pre_mvalid", {31'b0, mif.valid}, 32'h1);
    @(posedge clock); #1;
    reset     = 1'b1;
    cif.valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("midreset_mvalid", {31'b0, mif.valid}, 32'h0);
    chk("midreset_iready", {31'b0, cif.ready}, 32'h0);
    mrdy = 1'b1;
    do_reset();

    // Address wrap at the top of memory.
    do_fetch(32'hFFFF_FFFC, 2);
    do_fetch(32'h0000_0000, 0);
    chk("wrap_maddr0", mlog_at(0), 32'hFFFF_FFFC);
    chk("wrap_maddr1", mlog_at(1), 32'h0000_0000);

    repeat (2) @(posedge clock);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
